// File: rtl/pipe_hazard_controller.sv
// Hazard/stall control for the F/D/E/M/W pipe: load-use, branch flush,
// memory wait with watchdog fault, E-stage forwarding, stall counter.
module pipe_hazard_controller #(
    parameter int MAX_WAIT = 256
) (
    input  logic        clock,
    input  logic        async_reset,
    input  logic [5:0]  r1_D,
    input  logic [5:0]  r2_D,
    input  logic [5:0]  r1_E,
    input  logic [5:0]  r2_E,
    input  logic [5:0]  rd_E,
    input  logic [5:0]  rd_M,
    input  logic [5:0]  rd_W,
    input  logic        write_scalar_reg_E,
    input  logic        write_scalar_reg_M,
    input  logic        write_scalar_reg_W,
    input  logic        write_vector_reg_E,
    input  logic        write_vector_reg_M,
    input  logic        write_vector_reg_W,
    input  logic [1:0]  result_source_E,
    input  logic        branch_taken_E,
    input  logic        memory_transaction_M,
    input  logic        mem_ready,
    output logic        enable_F,
    output logic        enable_D,
    output logic        enable_E,
    output logic        enable_M,
    output logic        enable_W,
    output logic        flush_D_n,
    output logic        flush_E_n,
    output logic [1:0]  forward_0_E,
    output logic [1:0]  forward_1_E,
    output logic        mem_valid,
    output logic        mem_error,
    output logic [31:0] stall_cycles
);

    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] wait_count;
    logic [CW-1:0] wait_next;
    logic          mem_stall;
    logic          load_use;
    logic          halt;

    // Scalar x0 never matches; vector v0 (id 32) is a real register.
    function automatic logic hit(
        input logic [5:0] p,
        input logic [5:0] c,
        input logic       ws,
        input logic       wv
    );
        return (p == c) && (p[5] ? wv : ((p[4:0] != 5'd0) && ws));
    endfunction

    always_comb begin
        forward_0_E = 2'b00;
        if (hit(rd_M, r1_E, write_scalar_reg_M, write_vector_reg_M))
            forward_0_E = 2'b10;
        else if (hit(rd_W, r1_E, write_scalar_reg_W, write_vector_reg_W))
            forward_0_E = 2'b01;
    end

    always_comb begin
        forward_1_E = 2'b00;
        if (hit(rd_M, r2_E, write_scalar_reg_M, write_vector_reg_M))
            forward_1_E = 2'b10;
        else if (hit(rd_W, r2_E, write_scalar_reg_W, write_vector_reg_W))
            forward_1_E = 2'b01;
    end

    assign load_use = (result_source_E == 2'b01) &&
        (hit(rd_E, r1_D, write_scalar_reg_E, write_vector_reg_E) ||
         hit(rd_E, r2_D, write_scalar_reg_E, write_vector_reg_E));

    assign mem_stall = memory_transaction_M && !mem_ready;
    assign halt      = (state == FAULT) || mem_stall;
    assign mem_valid = memory_transaction_M && (state != FAULT);

    always_comb begin
        enable_F  = 1'b1;
        enable_D  = 1'b1;
        enable_E  = 1'b1;
        enable_M  = 1'b1;
        enable_W  = 1'b1;
        flush_D_n = 1'b1;
        flush_E_n = 1'b1;
        priority case (1'b1)
            halt: begin
                enable_F = 1'b0;
                enable_D = 1'b0;
                enable_E = 1'b0;
                enable_M = 1'b0;
                enable_W = 1'b0;
            end
            branch_taken_E: begin
                flush_D_n = 1'b0;
                flush_E_n = 1'b0;
            end
            load_use: begin
                enable_F  = 1'b0;
                enable_D  = 1'b0;
                flush_E_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_count;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                    wait_next  = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else if (wait_count == LAST) begin
                    state_next = FAULT;
                end else begin
                    wait_next = wait_count + CW'(1);
                end
            end
            FAULT: state_next = FAULT;
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state        <= RUN;
            wait_count   <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state      <= state_next;
            wait_count <= wait_next;
            if (state_next == FAULT)
                mem_error <= 1'b1;
            if (!enable_F && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Bench for pipe_hazard_controller: directed scenarios plus random
// traffic against a cycle-level reference model.
module tb_pipe_hazard_controller;

    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        async_reset = 1'b0;
    logic [5:0]  r1_D, r2_D, r1_E, r2_E, rd_E, rd_M, rd_W;
    logic        write_scalar_reg_E, write_scalar_reg_M, write_scalar_reg_W;
    logic        write_vector_reg_E, write_vector_reg_M, write_vector_reg_W;
    logic [1:0]  result_source_E;
    logic        branch_taken_E, memory_transaction_M, mem_ready;
    logic        enable_F, enable_D, enable_E, enable_M, enable_W;
    logic        flush_D_n, flush_E_n;
    logic [1:0]  forward_0_E, forward_1_E;
    logic        mem_valid, mem_error;
    logic [31:0] stall_cycles;
    logic [11:0] got;
    logic [6:0]  ctl;

    int errors = 0;
    int checks = 0;

    bit              m_fault;
    int              m_run;
    longint unsigned m_stall;

    pipe_hazard_controller #(.MAX_WAIT(MW)) dut (
        .clock(clock), .async_reset(async_reset),
        .r1_D(r1_D), .r2_D(r2_D), .r1_E(r1_E), .r2_E(r2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .write_scalar_reg_E(write_scalar_reg_E),
        .write_scalar_reg_M(write_scalar_reg_M),
        .write_scalar_reg_W(write_scalar_reg_W),
        .write_vector_reg_E(write_vector_reg_E),
        .write_vector_reg_M(write_vector_reg_M),
        .write_vector_reg_W(write_vector_reg_W),
        .result_source_E(result_source_E),
        .branch_taken_E(branch_taken_E),
        .memory_transaction_M(memory_transaction_M),
        .mem_ready(mem_ready),
        .enable_F(enable_F), .enable_D(enable_D), .enable_E(enable_E),
        .enable_M(enable_M), .enable_W(enable_W),
        .flush_D_n(flush_D_n), .flush_E_n(flush_E_n),
        .forward_0_E(forward_0_E), .forward_1_E(forward_1_E),
        .mem_valid(mem_valid), .mem_error(mem_error),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    assign got = {enable_F, enable_D, enable_E, enable_M, enable_W,
                  flush_D_n, flush_E_n, forward_0_E, forward_1_E, mem_valid};
    assign ctl = got[11:5];

    // Does producer id p feed consumer id c?
    function automatic bit feeds(input logic [5:0] p, input logic [5:0] c,
                                 input logic ws, input logic wv);
        if (p != c) return 1'b0;
        if (p >= 6'd32) return wv;
        return (p != 6'd0) && ws;
    endfunction

    function automatic logic [1:0] fwd(input logic [5:0] c);
        if (feeds(rd_M, c, write_scalar_reg_M, write_vector_reg_M)) return 2'b10;
        if (feeds(rd_W, c, write_scalar_reg_W, write_vector_reg_W)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model_out();
        logic [4:0] en;
        logic fd, fe;
        en = 5'b11111;
        fd = 1'b1;
        fe = 1'b1;
        if (m_fault) en = 5'b00000;
        else if (memory_transaction_M && !mem_ready) en = 5'b00000;
        else if (branch_taken_E) begin
            fd = 1'b0;
            fe = 1'b0;
        end else if (result_source_E == 2'b01 &&
                 (feeds(rd_E, r1_D, write_scalar_reg_E, write_vector_reg_E) ||
                  feeds(rd_E, r2_D, write_scalar_reg_E, write_vector_reg_E))) begin
            en = 5'b00111;
            fe = 1'b0;
        end
        return {en, fd, fe, fwd(r1_E), fwd(r2_E),
                memory_transaction_M && !m_fault};
    endfunction

    task automatic clear_inputs();
        {r1_D, r2_D, r1_E, r2_E, rd_E, rd_M, rd_W} = '0;
        {write_scalar_reg_E, write_scalar_reg_M, write_scalar_reg_W} = '0;
        {write_vector_reg_E, write_vector_reg_M, write_vector_reg_W} = '0;
        result_source_E = 2'b00;
        branch_taken_E = 1'b0;
        memory_transaction_M = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_fault = 1'b0;
        m_run = 0;
        m_stall = 0;
    endtask

    task automatic tick();
        logic [11:0] e;
        e = model_out();
        @(posedge clock);
        if (async_reset) begin
            if (!e[11] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (!m_fault) begin
                if (memory_transaction_M && !mem_ready) begin
                    m_run++;
                    if (m_run >= MW) m_fault = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        async_reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        async_reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        async_reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got !== 12'b11111_11_00_00_0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", got, 12'b111111100000);
        end
        checks++;
        if (stall_cycles !== 32'd0 || mem_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs stall=%0d err=%b exp 0/0", stall_cycles, mem_error);
        end
        apply_reset();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rd_M = 6'd5; write_scalar_reg_M = 1'b1;
        rd_W = 6'd5; write_scalar_reg_W = 1'b1;
        r1_E = 6'd5;
        #1;
        checks++;
        if (forward_0_E !== 2'b10) begin
            errors++;
            $display("FAIL fwd_m_priority got=%b exp=10", forward_0_E);
        end
        write_scalar_reg_M = 1'b0;
        #1;
        checks++;
        if (forward_0_E !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w got=%b exp=01", forward_0_E);
        end
        r1_E = 6'd0; rd_M = 6'd0; rd_W = 6'd0;
        write_scalar_reg_M = 1'b1;
        #1;
        checks++;
        if (forward_0_E !== 2'b00) begin
            errors++;
            $display("FAIL fwd_x0 got=%b exp=00", forward_0_E);
        end
        clear_inputs();
        rd_M = 6'd33; write_vector_reg_M = 1'b1; r2_E = 6'd33;
        #1;
        checks++;
        if (forward_1_E !== 2'b10) begin
            errors++;
            $display("FAIL fwd_vec_m got=%b exp=10", forward_1_E);
        end
        write_vector_reg_M = 1'b0; write_scalar_reg_M = 1'b1;
        #1;
        checks++;
        if (forward_1_E !== 2'b00) begin
            errors++;
            $display("FAIL fwd_vec_scalar_flag got=%b exp=00", forward_1_E);
        end
        clear_inputs();
        rd_W = 6'd32; write_vector_reg_W = 1'b1; r1_E = 6'd32;
        #1;
        checks++;
        if (forward_0_E !== 2'b01) begin
            errors++;
            $display("FAIL fwd_v0 got=%b exp=01", forward_0_E);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        result_source_E = 2'b01; write_scalar_reg_E = 1'b1;
        rd_E = 6'd7; r2_D = 6'd7;
        #1;
        checks++;
        if (ctl !== 7'b00111_11 - 7'd1) begin
            errors++;
            $display("FAIL load_use_ctl got=%b exp=0011110", ctl);
        end
        tick();
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL load_use_stall got=%0d exp=1", stall_cycles);
        end
        rd_E = 6'd0;
        #1;
        checks++;
        if (ctl !== 7'b1111111) begin
            errors++;
            $display("FAIL load_use_clear got=%b exp=1111111", ctl);
        end
        tick();
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL load_use_after got=%0d exp=1", stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        apply_reset();
        branch_taken_E = 1'b1;
        result_source_E = 2'b01; write_scalar_reg_E = 1'b1;
        rd_E = 6'd3; r1_D = 6'd3;
        #1;
        checks++;
        if (ctl !== 7'b1111100) begin
            errors++;
            $display("FAIL branch_flush got=%b exp=1111100", ctl);
        end
        memory_transaction_M = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== 7'b0000011) begin
            errors++;
            $display("FAIL branch_in_wait got=%b exp=0000011", ctl);
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        memory_transaction_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 7'b0000011 || mem_valid !== 1'b1) begin
                errors++;
                $display("FAIL mem_wait_c%0d ctl=%b valid=%b exp 0000011/1", i, ctl, mem_valid);
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b1111111) begin
            errors++;
            $display("FAIL mem_wait_ready got=%b exp=1111111", ctl);
        end
        tick();
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL mem_wait_stall got=%0d exp=3", stall_cycles);
        end
        mem_ready = 1'b0;
        repeat (MW - 1) tick();
        mem_ready = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (mem_error !== 1'b0 || stall_cycles !== 32'd6) begin
            errors++;
            $display("FAIL mem_wait_rerun err=%b stall=%0d exp 0/6", mem_error, stall_cycles);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        memory_transaction_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < MW; i++) begin
            #1;
            checks++;
            if (ctl !== 7'b0000011 || mem_valid !== 1'b1 || mem_error !== 1'b0) begin
                errors++;
                $display("FAIL wd_wait_c%0d ctl=%b valid=%b err=%b", i, ctl, mem_valid, mem_error);
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_error !== 1'b1 || mem_valid !== 1'b0 || ctl !== 7'b0000011) begin
            errors++;
            $display("FAIL wd_fault err=%b valid=%b ctl=%b exp 1/0/0000011", mem_error, mem_valid, ctl);
        end
        tick();
        checks++;
        if (stall_cycles !== 32'd5 || mem_error !== 1'b1) begin
            errors++;
            $display("FAIL wd_fault_hold stall=%0d err=%b exp 5/1", stall_cycles, mem_error);
        end
        #2;
        async_reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got !== 12'b11111_11_00_00_1 || mem_error !== 1'b0 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL wd_reset got=%b err=%b stall=%0d", got, mem_error, stall_cycles);
        end
        apply_reset();
        memory_transaction_M = 1'b1; mem_ready = 1'b0;
        repeat (MW - 1) tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b1111111) begin
            errors++;
            $display("FAIL wd_ready_last got=%b exp=1111111", ctl);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_error !== 1'b0 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL wd_no_fault err=%b valid=%b exp 0/1", mem_error, mem_valid);
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        memory_transaction_M = 1'b1; mem_ready = 1'b0;
        repeat (2) tick();
        #2;
        async_reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (stall_cycles !== 32'd0 || mem_error !== 1'b0) begin
            errors++;
            $display("FAIL midwait_async stall=%0d err=%b exp 0/0", stall_cycles, mem_error);
        end
        clear_inputs();
        #1;
        checks++;
        if (got !== 12'b11111_11_00_00_0) begin
            errors++;
            $display("FAIL midwait_outputs got=%b exp=111111100000", got);
        end
        apply_reset();
        memory_transaction_M = 1'b1; mem_ready = 1'b0;
        repeat (MW - 1) tick();
        mem_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (mem_error !== 1'b0 || stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL midwait_count_cleared err=%b stall=%0d exp 0/3", mem_error, stall_cycles);
        end
        clear_inputs();
    endtask

    function automatic logic [5:0] rid();
        int r;
        r = $urandom_range(0, 7);
        return (r < 4) ? 6'(r) : 6'(28 + r);
    endfunction

    task automatic test_random();
        logic [11:0] e;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) apply_reset();
            r1_D = rid(); r2_D = rid(); r1_E = rid(); r2_E = rid();
            rd_E = rid(); rd_M = rid(); rd_W = rid();
            write_scalar_reg_E = 1'($urandom_range(0, 1));
            write_scalar_reg_M = 1'($urandom_range(0, 1));
            write_scalar_reg_W = 1'($urandom_range(0, 1));
            write_vector_reg_E = 1'($urandom_range(0, 1));
            write_vector_reg_M = 1'($urandom_range(0, 1));
            write_vector_reg_W = 1'($urandom_range(0, 1));
            result_source_E = 2'($urandom_range(0, 3));
            branch_taken_E = ($urandom_range(0, 4) == 0);
            memory_transaction_M = ($urandom_range(0, 9) < 4);
            mem_ready = ($urandom_range(0, 9) < 6);
            #1;
            e = model_out();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rand_out[%0d] got=%b exp=%b", i, got, e);
            end
            checks++;
            if (stall_cycles !== m_stall[31:0] || mem_error !== m_fault) begin
                errors++;
                $display("FAIL rand_regs[%0d] stall=%0d/%0d err=%b/%b", i,
                         stall_cycles, m_stall, mem_error, m_fault);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_watchdog();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_controller.md
# pipe_hazard_controller

Hazard and stall controller that drives the enabler and active-low sync_reset inputs of the F/D/E/M/W pipeline registers of the RV32I + vector core. It detects load-use hazards, taken-branch redirects and memory wait states, and produces the operand-forwarding selects for the execute stage. It also runs a memory-wait watchdog with a sticky fault state and a saturating stall-cycle counter.

## Interface
- MAX_WAIT, 256, consecutive not-ready memory cycles before fault; minimum 2.
- clock  in  1  core clock; all state updates on the rising edge.
- async_reset  in  1  asynchronous, active-low reset.
- r1_D, r2_D  in  6 each  source register ids in decode; bit5=1 selects a vector register, bits4:0 are the index.
- r1_E, r2_E, rd_E  in  6 each  source and destination ids in execute.
- rd_M, rd_W  in  6 each  destination ids in memory and writeback.
- write_scalar_reg_E/M/W, write_vector_reg_E/M/W  in  1 each  register-write flags per stage.
- result_source_E  in  2  execute-stage result source; 2'b01 = memory load.
- branch_taken_E  in  1  PC redirect resolved in execute.
- memory_transaction_M  in  1  memory stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- enable_F, enable_D, enable_E, enable_M, enable_W  out  1 each  pipeline register enablers.
- flush_D_n, flush_E_n  out  1 each  active-low sync_reset for the D and E registers.
- forward_0_E, forward_1_E  out  2 each  operand select: 00 = register file, 01 = W result, 10 = M result.
- mem_valid  out  1  memory request valid.
- mem_error  out  1  sticky watchdog fault.
- stall_cycles  out  32  saturating count of cycles with enable_F=0.

## Operation
- Match rule for ids a (producer) and b (consumer): a==b and either (bit5=0, a!=0, producer write_scalar_reg) or (bit5=1, producer write_vector_reg). Scalar x0 never matches. Vector v0 (6'd32) is a real register.
- Forwarding, combinational. forward_0_E = 10 if rd_M matches r1_E. Otherwise 01 if rd_W matches r1_E. Otherwise 00. forward_1_E uses r2_E with the same rule. M has priority over W.
- Load-use, combinational. Condition: result_source_E==01 and rd_E matches r1_D or r2_D.
  - Response: enable_F=0, enable_D=0, flush_E_n=0. Inserts exactly one bubble.
  - The hazard clears automatically next cycle.
- Branch: when branch_taken_E=1, flush_D_n=0 and flush_E_n=0, with all enables 1.
- Memory wait: when memory_transaction_M=1 and mem_ready=0, all five enables are 0 and both flushes are 1. The W stage is frozen, which keeps W forwarding valid; re-writing the same W result is idempotent.
- Priority: FAULT > memory wait > branch > load-use. Branch and load-use are suppressed during a memory wait and re-evaluated once the pipe releases.
- mem_valid = memory_transaction_M and state!=FAULT.
- FSM states: RUN, MEM_WAIT, FAULT.
  - RUN -> MEM_WAIT on memory_transaction_M and !mem_ready; wait_count <= 1.
  - MEM_WAIT with mem_ready=1 -> RUN. Enables are high in that same cycle.
  - MEM_WAIT with mem_ready=0 and wait_count==MAX_WAIT-1 -> FAULT. Otherwise wait_count increments.
  - FAULT: all enables 0, flushes 1, mem_valid 0, mem_error 1. Only async_reset exits FAULT.
- stall_cycles increments on every cycle with enable_F=0, including FAULT cycles, and saturates at 32'hFFFFFFFF.

## Timing
- Enables, flushes, forwards and mem_valid are combinational from the inputs and the state, with zero-cycle latency. The registered elements are state, wait_count, mem_error and stall_cycles.
- Reset: state=RUN, wait_count=0, mem_error=0, stall_cycles=0. With all inputs 0 after reset: enables=1, flushes=1, forwards=00, mem_valid=0.
- The pipeline registers give sync_reset priority over enabler. flush_E_n=0 with enable_E=1 therefore loads a bubble.
- Watchdog: with MAX_WAIT consecutive not-ready cycles, the first not-ready cycle is cycle 1 (in RUN). The edge ending cycle MAX_WAIT enters FAULT. mem_ready=1 in cycle MAX_WAIT avoids the fault.
- async_reset mid-MEM_WAIT or in FAULT returns to RUN immediately and clears all counters.

## Test plan
- Forwarding:
  - rd_M=5 with write_scalar_reg_M, rd_W=5 with write_scalar_reg_W, r1_E=5 -> forward_0_E=10.
  - Clear write_scalar_reg_M -> forward_0_E=01.
  - r1_E=0 -> forward_0_E=00.
  - Vector case: rd_M=6'd33 with write_vector_reg_M, r2_E=33 -> forward_1_E=10. Same ids with only write_scalar_reg_M -> forward_1_E=00.
- Load-use: result_source_E=01, write_scalar_reg_E=1, rd_E=7, r2_D=7 -> for one cycle enable_F=enable_D=0, flush_E_n=0, and stall_cycles increments by 1. Next cycle (rd_E=0) the pipe runs normally.
- Branch: branch_taken_E=1 -> flush_D_n=flush_E_n=0 with all enables 1. The same with memory_transaction_M=1 and mem_ready=0 -> no flush and all enables 0.
- Memory wait: memory_transaction_M=1 with mem_ready low for 3 cycles, then high -> enables 0 for 3 cycles, 1 in the ready cycle, state returns to RUN, stall_cycles=3.
- Watchdog with MAX_WAIT=4:
  - 4 not-ready cycles -> FAULT, mem_error=1, mem_valid=0, enables held 0.
  - async_reset low -> all registered state is cleared.
  - Ready in the 4th cycle -> no fault.
- Reset mid-wait: assert async_reset during MEM_WAIT -> outputs return to reset values immediately, without waiting for a clock edge.
